// File: rtl/pulse_train_sequencer_pkg.sv
// Shared types and default widths for the pulse train sequencer.
package pulse_seq_pkg;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_REP_W = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    DONE
  } state_t;

  // One table entry: pulse high length, gap length and pulse count.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] high;
    logic [DEF_CNT_W-1:0] low;
    logic [DEF_REP_W-1:0] reps;
  } pulse_entry_t;

  // An entry with no high time or no pulses produces nothing and is skipped.
  function automatic logic entry_is_empty(input pulse_entry_t e);
    return (e.high == '0) || (e.reps == '0);
  endfunction

endpackage

// File: rtl/pulse_train_sequencer_engine.sv
// Pulse engine: times one pulse (high phase then optional low phase) and
// drives the registered pulse / pulse_active outputs one cycle behind its
// counters. pulse_end marks the last cycle of the pulse period so the
// sequencer can reload back-to-back without a dead cycle.
module pulse_engine #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  output logic             pulse,
  output logic             pulse_active,
  output logic             high_end,
  output logic             pulse_end
);

  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] lo_cnt;
  logic             fresh;
  logic             in_high;

  assign in_high   = (hi_cnt != '0);
  assign high_end  = (hi_cnt == CNT_W'(1));
  assign pulse_end = (high_end && (lo_cnt == '0)) ||
                     (!in_high && (lo_cnt == CNT_W'(1)));

  // Down-count the high phase, then the low phase; register the outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hi_cnt       <= '0;
      lo_cnt       <= '0;
      fresh        <= 1'b0;
      pulse        <= 1'b0;
      pulse_active <= 1'b0;
    end else begin
      pulse        <= in_high;
      pulse_active <= fresh;
      fresh        <= load;
      if (load) begin
        hi_cnt <= high_len;
        lo_cnt <= low_len;
      end else if (in_high) begin
        hi_cnt <= hi_cnt - CNT_W'(1);
      end else if (lo_cnt != '0) begin
        lo_cnt <= lo_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pulse_train_sequencer.sv
// Pulse train sequencer: holds a host-written table of {high, low, reps}
// entries and walks the pulse engine through them, reporting busy/done.
// busy covers the registered done strobe, so busy falling means the train
// is fully finished and the table may be rewritten.
module pulse_train_sequencer
  import pulse_seq_pkg::*;
#(
  parameter  int CNT_W = DEF_CNT_W,
  parameter  int REP_W = DEF_REP_W,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic [IDX_W:0]   num_entries,
  input  logic             start,
  input  logic             stop,
  output logic             pulse,
  output logic             pulse_active,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] entry_idx
);

  localparam logic [IDX_W:0] DEPTH_N = (IDX_W+1)'(DEPTH);

  state_t           state_q, state_d;
  pulse_entry_t     table_q [DEPTH];
  pulse_entry_t     entry;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   num_q, num_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             done_q;
  logic             last_entry;
  logic             eng_load;
  logic             eng_clear;
  logic             high_end;
  logic             pulse_end;

  assign entry      = table_q[idx_q];
  assign last_entry = (({1'b0, idx_q} + (IDX_W+1)'(1)) == num_q);
  assign busy       = (state_q != IDLE) || done_q;
  assign cfg_ready  = !busy;
  assign done       = done_q;
  assign entry_idx  = idx_q;

  // Host table writes, accepted only while idle.
  // NOTE: the table is deliberately not reset; it is plain storage that the
  // host must write before use, which keeps it mappable to memory.
  always_ff @(posedge clk) begin
    if (cfg_valid && cfg_ready) begin
      table_q[cfg_addr] <= '{high: cfg_high, low: cfg_low, reps: cfg_reps};
    end
  end

  // FSM state, entry/rep counters and the registered done strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      rep_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      rep_q   <= rep_d;
      done_q  <= (state_q == DONE);
    end
  end

  // Next-state, counter updates and engine control.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    rep_d     = rep_q;
    eng_load  = 1'b0;
    eng_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop && (num_entries != '0) && !done_q) begin
          state_d = LOAD;
          idx_d   = '0;
          num_d   = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d   = IDLE;
          idx_d     = '0;
          eng_clear = 1'b1;
        end else if (entry_is_empty(entry)) begin
          if (last_entry) state_d = DONE;
          else            idx_d   = idx_q + IDX_W'(1);
        end else begin
          eng_load = 1'b1;
          rep_d    = entry.reps;
          state_d  = HIGH;
        end
      end
      HIGH, LOW: begin
        if (stop) begin
          state_d   = IDLE;
          idx_d     = '0;
          eng_clear = 1'b1;
        end else if (pulse_end) begin
          if (rep_q > REP_W'(1)) begin
            rep_d    = rep_q - REP_W'(1);
            eng_load = 1'b1;
            state_d  = HIGH;
          end else if (!last_entry) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end else if ((state_q == HIGH) && high_end) begin
          state_d = LOW;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  pulse_engine #(
    .CNT_W(CNT_W)
  ) u_engine (
    .clk         (clk),
    .rst         (rst),
    .load        (eng_load),
    .clear       (eng_clear),
    .high_len    (entry.high),
    .low_len     (entry.low),
    .pulse       (pulse),
    .pulse_active(pulse_active),
    .high_end    (high_end),
    .pulse_end   (pulse_end)
  );

endmodule
